alarm_ctrl: RTL and testbench

Alarm controller between the timekeeping stage and the melody stage. Holds a user-set alarm time and debounces the four user buttons. Compares the alarm time against the running hour/min/sec and asserts ring, which drives the melody player's enable input. Supports arm, disarm, set, stop and snooze, with an automatic ring timeout.

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/alarm_ctrl_btn_debounce.sv | 48 ++++
 rtl/alarm_ctrl.sv | 138 +++++++++++++
 tb/tb_alarm_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared encodings and helpers for the alarm controller: FSM states,
// button roles and the wrap limits of the alarm time.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        SET      = 3'd1,
        ARMED    = 3'd2,
        RINGING  = 3'd3,
        SNOOZE   = 3'd4
    } state_t;

    localparam int BTN_MODE = 0;
    localparam int BTN_HOUR = 1;
    localparam int BTN_MIN  = 2;
    localparam int BTN_ARM  = 3;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;

    function automatic logic [4:0] inc_hour(input logic [4:0] h);
        return (h >= MAX_HOUR) ? 5'd0 : h + 5'd1;
    endfunction

    // Minutes wrap on their own; there is deliberately no carry into the hour.
    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return (m >= MAX_MIN) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_btn_debounce.sv
// One push button: 2-FF synchroniser, stability-window debounce and a
// one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            pulse   <= level & ~level_q;
            // Any cycle where the input agrees with the level restarts the window.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: holds the alarm time, debounces the buttons and drives
// the melody enable (ring) from an arm/set/ring/snooze state machine.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [3:0] btn,
    output logic       ring,
    output logic       armed,
    output logic       set_mode,
    output logic [4:0] al_hour,
    output logic [5:0] al_min,
    output logic [2:0] state
);

    localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);

    logic [3:0]    p;
    logic [5:0]    sec_d;
    logic          tick;
    logic          match;
    state_t        state_q;
    state_t        state_n;
    logic [4:0]    al_hour_n;
    logic [5:0]    al_min_n;
    logic [RW-1:0] ring_cnt_q;
    logic [RW-1:0] ring_cnt_n;
    logic [SW-1:0] snz_cnt_q;
    logic [SW-1:0] snz_cnt_n;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .pulse (p[i])
        );
    end

    assign tick  = (sec != sec_d);
    assign match = tick && (sec == 6'd0) && (hour == al_hour) && (min == al_min);
    assign state = state_q;

    always_comb begin
        state_n    = state_q;
        al_hour_n  = al_hour;
        al_min_n   = al_min;
        ring_cnt_n = ring_cnt_q;
        snz_cnt_n  = snz_cnt_q;
        case (state_q)
            DISARMED: begin
                if (p[BTN_MODE])     state_n = SET;
                else if (p[BTN_ARM]) state_n = ARMED;
            end
            SET: begin
                if (p[BTN_MODE]) begin
                    state_n = DISARMED;
                end else if (p[BTN_ARM]) begin
                    state_n = ARMED;
                end else begin
                    if (p[BTN_HOUR]) al_hour_n = inc_hour(al_hour);
                    if (p[BTN_MIN])  al_min_n  = inc_min(al_min);
                end
            end
            ARMED: begin
                if (p[BTN_ARM]) begin
                    state_n = DISARMED;
                end else if (p[BTN_MODE]) begin
                    state_n = SET;
                end else if (match) begin
                    state_n    = RINGING;
                    ring_cnt_n = '0;
                end
            end
            RINGING: begin
                if (p[BTN_ARM]) begin
                    state_n = ARMED;
                end else if (p[BTN_HOUR] || p[BTN_MIN]) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = '0;
                end else if (tick) begin
                    if (ring_cnt_q == RING_LAST) state_n = ARMED;
                    else                         ring_cnt_n = ring_cnt_q + RW'(1);
                end
            end
            SNOOZE: begin
                if (p[BTN_ARM]) begin
                    state_n = ARMED;
                end else if (tick) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                    end else begin
                        snz_cnt_n = snz_cnt_q + SW'(1);
                    end
                end
            end
            default: state_n = DISARMED;
        endcase
    end

    // Status outputs are registered from the next state so they move with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DISARMED;
            al_hour    <= '0;
            al_min     <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            sec_d      <= '0;
            ring       <= 1'b0;
            armed      <= 1'b0;
            set_mode   <= 1'b0;
        end else begin
            state_q    <= state_n;
            al_hour    <= al_hour_n;
            al_min     <= al_min_n;
            ring_cnt_q <= ring_cnt_n;
            snz_cnt_q  <= snz_cnt_n;
            sec_d      <= sec;
            ring       <= (state_n == RINGING);
            armed      <= (state_n == ARMED) || (state_n == RINGING) || (state_n == SNOOZE);
            set_mode   <= (state_n == SET);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short debounce, ring and snooze windows.
module tb_alarm_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [3:0] btn;
    logic       ring;
    logic       armed;
    logic       set_mode;
    logic [4:0] al_hour;
    logic [5:0] al_min;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_SET      = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_RINGING  = 3'd3;
    localparam logic [2:0] S_SNOOZE   = 3'd4;

    alarm_ctrl #(
        .DB_CYCLES  (4),
        .RING_SEC   (5),
        .SNOOZE_SEC (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .btn      (btn),
        .ring     (ring),
        .armed    (armed),
        .set_mode (set_mode),
        .al_hour  (al_hour),
        .al_min   (al_min),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        cycles(10);
        btn = 4'b0000;
        cycles(10);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h;
        min  = m;
        sec  = s;
    endtask

    initial begin
        reset = 1'b1;
        btn   = 4'b0000;
        set_time(5'd0, 6'd0, 6'd0);
        #12;
        check("reset_state", 32'(state), 32'(S_DISARMED));
        check("reset_ring", 32'(ring), 0);
        check("reset_al_hour", 32'(al_hour), 0);
        check("reset_al_min", 32'(al_min), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles(2);

        // Set alarm to 03:02 and arm
        press(4'b0001);
        check("enter_set", 32'(state), 32'(S_SET));
        check("set_mode_hi", 32'(set_mode), 1);
        repeat (3) press(4'b0010);
        repeat (2) press(4'b0100);
        check("al_hour_3", 32'(al_hour), 3);
        check("al_min_2", 32'(al_min), 2);
        press(4'b1000);
        check("armed_state", 32'(state), 32'(S_ARMED));
        check("armed_hi", 32'(armed), 1);
        check("set_mode_lo", 32'(set_mode), 0);
        check("armed_ring_lo", 32'(ring), 0);

        // Match at 03:02:00 then timeout after 5 ticks
        set_time(5'd3, 6'd1, 6'd59);
        cycles(3);
        check("pre_match_ring", 32'(ring), 0);
        set_time(5'd3, 6'd2, 6'd0);
        cycles(1);
        check("match_ring", 32'(ring), 1);
        check("match_state", 32'(state), 32'(S_RINGING));
        for (int s = 1; s <= 4; s++) begin
            set_time(5'd3, 6'd2, 6'(s));
            cycles(2);
        end
        check("ring_after_4_ticks", 32'(ring), 1);
        set_time(5'd3, 6'd2, 6'd5);
        cycles(2);
        check("timeout_ring", 32'(ring), 0);
        check("timeout_state", 32'(state), 32'(S_ARMED));
        set_time(5'd3, 6'd2, 6'd6);
        cycles(2);
        set_time(5'd3, 6'd2, 6'd7);
        cycles(2);
        check("no_retrigger_0207", 32'(ring), 0);
        set_time(5'd3, 6'd3, 6'd0);
        cycles(2);
        check("no_retrigger_0300", 32'(ring), 0);
        check("still_armed", 32'(state), 32'(S_ARMED));

        // Snooze via a time jump back onto the alarm
        set_time(5'd3, 6'd1, 6'd59);
        cycles(2);
        set_time(5'd3, 6'd2, 6'd0);
        cycles(1);
        check("jump_ring", 32'(ring), 1);
        press(4'b0100);
        check("snooze_ring", 32'(ring), 0);
        check("snooze_state", 32'(state), 32'(S_SNOOZE));
        check("snooze_armed", 32'(armed), 1);
        set_time(5'd3, 6'd2, 6'd1);
        cycles(2);
        set_time(5'd3, 6'd2, 6'd2);
        cycles(2);
        check("snooze_2_ticks", 32'(ring), 0);
        set_time(5'd3, 6'd2, 6'd3);
        cycles(2);
        check("rering", 32'(ring), 1);
        check("rering_state", 32'(state), 32'(S_RINGING));
        press(4'b1000);
        check("stop_ring", 32'(ring), 0);
        check("stop_state", 32'(state), 32'(S_ARMED));

        // Wrap 23:59 -> 00:00 with simultaneous hour/min presses
        press(4'b0001);
        repeat (20) press(4'b0010);
        repeat (57) press(4'b0100);
        check("al_hour_23", 32'(al_hour), 23);
        check("al_min_59", 32'(al_min), 59);
        press(4'b0110);
        check("wrap_hour", 32'(al_hour), 0);
        check("wrap_min", 32'(al_min), 0);
        press(4'b1000);
        check("rearm_state", 32'(state), 32'(S_ARMED));

        // Bouncing arm button must not register
        for (int i = 0; i < 10; i++) begin
            btn[3] = ~btn[3];
            cycles(2);
        end
        cycles(10);
        check("bounce_state", 32'(state), 32'(S_ARMED));

        // Arm press lands in the same cycle as a match at 00:00:00
        set_time(5'd23, 6'd59, 6'd59);
        cycles(2);
        btn = 4'b1000;
        cycles(7);
        set_time(5'd0, 6'd0, 6'd0);
        cycles(1);
        check("prio_state", 32'(state), 32'(S_DISARMED));
        check("prio_ring", 32'(ring), 0);
        cycles(2);
        btn = 4'b0000;
        cycles(10);
        check("prio_ring_after", 32'(ring), 0);

        // Asynchronous reset while ringing at 01:00
        press(4'b0001);
        press(4'b0010);
        press(4'b1000);
        set_time(5'd1, 6'd0, 6'd59);
        cycles(2);
        set_time(5'd1, 6'd0, 6'd0);
        cycles(1);
        check("pre_reset_ring", 32'(ring), 1);
        check("pre_reset_al_hour", 32'(al_hour), 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_ring", 32'(ring), 0);
        check("async_state", 32'(state), 32'(S_DISARMED));
        check("async_al_hour", 32'(al_hour), 0);
        check("async_al_min", 32'(al_min), 0);
        cycles(2);
        reset = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
